reg_file_mp_sb: RTL and testbench

Parametrised multi-read-port register file with write-to-read bypass and a per-register pending-write scoreboard. It is the next-generation CPU-core register file for the pipelined core. It sits between the decode/issue stage and writeback. Decode reads operands and busy flags, issue reserves a destination register, and writeback commits data and releases the reservation.

---
 rtl/cpu_core_pkg.sv | 9 +
 rtl/reg_scoreboard.sv | 51 +++++
 rtl/reg_file_mp_sb.sv | 80 ++++++++
 tb/tb_reg_file_mp_sb.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// Shared definitions for the pipelined CPU core: default datapath widths and
// the hard-wired zero register address.
package cpu_core_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int ZERO_REG       = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at
// writeback or flush, with a registered population count of busy registers.
module reg_scoreboard
    import cpu_core_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen,
    input  logic [ADDR_WIDTH-1:0]      waddr,
    input  logic                       iss_valid,
    input  logic [ADDR_WIDTH-1:0]      iss_addr,
    input  logic                       flush,
    output logic [(2**ADDR_WIDTH)-1:0] busy,
    output logic [ADDR_WIDTH:0]        busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_WIDTH:0] cnt_nxt;

    // NOTE: combinational blocks use blocking assignments and assign every
    // output a default first, so later statements override and no latch forms.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (wen && waddr != ZERO_ADDR)
            busy_nxt[waddr] = 1'b0;
        // Issue is applied last so a new reservation beats writeback and flush.
        if (iss_valid && iss_addr != ZERO_ADDR)
            busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;

        cnt_nxt = '0;
        for (int i = 1; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-read-port register file with optional write-to-read bypass and a
// pending-write scoreboard; register 0 reads as zero and has no storage.
module reg_file_mp_sb
    import cpu_core_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic                           wen,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           iss_valid,
    input  logic [ADDR_WIDTH-1:0]          iss_addr,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] mem [1:DEPTH-1];
    logic [DEPTH-1:0]      busy;

    reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .waddr    (waddr),
        .iss_valid(iss_valid),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // NOTE: this array is deliberately reset because every register must read
    // zero after reset; that forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wen && waddr != ZERO_ADDR) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic                  fwd;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra  = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign fwd = (BYPASS != 0) && wen && (waddr == ra);

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (ra != ZERO_ADDR) begin
                if (fwd) begin
                    rd = wdata;
                end else begin
                    rd = mem[ra];
                    rb = busy[ra];
                end
            end
        end

        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rbusy[p]                          = rb;
    end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Scoreboard bench: drives a bypassing and a non-bypassing instance with the
// same stimulus and compares both against an array-based reference model.
module tb_reg_file_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    typedef struct packed {
        logic [NR-1:0][DW-1:0] rd_bp;
        logic [NR-1:0]         rb_bp;
        logic [NR-1:0][DW-1:0] rd_nb;
        logic [NR-1:0]         rb_nb;
        logic [AW:0]           cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     waddr = '0;
    logic              wen = 1'b0;
    logic [DW-1:0]     wdata = '0;
    logic [NR*AW-1:0]  raddr = '0;
    logic              iss_valid = 1'b0;
    logic [AW-1:0]     iss_addr = '0;
    logic              flush = 1'b0;
    logic [NR*DW-1:0]  rdata_bp, rdata_nb;
    logic [NR-1:0]     rbusy_bp, rbusy_nb;
    logic [AW:0]       cnt_bp, cnt_nb;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [DW-1:0] m_regs [32];
    logic          m_busy [32];

    always #5 clk = ~clk;

    reg_file_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .waddr(waddr), .wen(wen), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_bp), .rbusy(rbusy_bp),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_bp)
    );

    reg_file_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .waddr(waddr), .wen(wen), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_nb)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    endtask

    function automatic int m_count();
        int c = 0;
        for (int a = 1; a < 32; a++) if (m_busy[a]) c++;
        return c;
    endfunction

    // Expected read of one port, from the model state before the coming edge.
    task automatic m_read(input logic [AW-1:0] a, input bit bypass,
                          output logic [DW-1:0] d, output logic b);
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else if (bypass && wen && waddr == a) begin
            d = wdata; b = 1'b0;
        end else begin
            d = m_regs[a]; b = m_busy[a];
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic iv, input logic [AW-1:0] ia,
                        input logic fl, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; wen = w; waddr = wa; wdata = wd;
        iss_valid = iv; iss_addr = ia; flush = fl;
        raddr = {ra1, ra0};
        for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            a = (p == 0) ? ra0 : ra1;
            m_read(a, 1'b1, e.rd_bp[p], e.rb_bp[p]);
            m_read(a, 1'b0, e.rd_nb[p], e.rb_nb[p]);
        end
        e.cnt = (AW+1)'(m_count());
        q.push_back(e);
        if (r) begin
            for (int a = 0; a < 32; a++) begin
                m_regs[a] = '0; m_busy[a] = 1'b0;
            end
        end else begin
            if (w && wa != 0) begin
                m_regs[wa] = wd; m_busy[wa] = 1'b0;
            end
            if (fl)
                for (int a = 0; a < 32; a++) m_busy[a] = 1'b0;
            if (iv && ia != 0) m_busy[ia] = 1'b1;
        end
    endtask

    task automatic rd(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        step(0, 0, 0, 0, 0, 0, 0, ra0, ra1);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int p = 0; p < NR; p++) begin
                check($sformatf("bp_rdata%0d", p), rdata_bp[p*DW +: DW], e.rd_bp[p]);
                check($sformatf("bp_rbusy%0d", p), DW'(rbusy_bp[p]), DW'(e.rb_bp[p]));
                check($sformatf("nb_rdata%0d", p), rdata_nb[p*DW +: DW], e.rd_nb[p]);
                check($sformatf("nb_rbusy%0d", p), DW'(rbusy_nb[p]), DW'(e.rb_nb[p]));
            end
            check("bp_busy_cnt", DW'(cnt_bp), DW'(e.cnt));
            check("nb_busy_cnt", DW'(cnt_nb), DW'(e.cnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 32; a++) begin
            m_regs[a] = '0; m_busy[a] = 1'b0;
        end
        @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 32'hFFFF_FFFF, 1, 3, 0, 3, 0);

        for (int a = 0; a < 32; a++) rd(AW'(a), AW'(31 - a));

        step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 0);
        rd(5, 0);
        step(0, 1, 0, 32'h0000_1234, 0, 0, 0, 0, 0);
        rd(0, 0);

        step(0, 1, 7, 32'h1111_1111, 1, 7, 0, 7, 7);
        step(0, 1, 7, 32'hA5A5_A5A5, 0, 0, 0, 7, 7);
        rd(7, 7);

        step(0, 0, 0, 0, 1, 3, 0, 3, 4);
        step(0, 0, 0, 0, 1, 4, 0, 3, 4);
        step(0, 0, 0, 0, 1, 3, 0, 3, 4);
        step(0, 1, 3, 32'h0000_0333, 1, 3, 0, 3, 4);
        step(0, 1, 4, 32'h0000_0444, 0, 0, 0, 3, 4);
        rd(4, 3);

        for (int a = 1; a <= 6; a++) step(0, 0, 0, 0, 1, AW'(a), 0, AW'(a), 5);
        step(0, 0, 0, 0, 1, 9, 1, 3, 9);
        rd(5, 9);
        rd(3, 1);

        step(0, 1, 10, 32'h55, 0, 0, 0, 10, 0);
        step(0, 0, 0, 0, 1, 10, 0, 10, 0);
        step(1, 1, 10, 32'h77, 0, 0, 0, 10, 9);
        rd(10, 9);

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa, ia, r0, r1;
            wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ia = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 2) == 0) ? ia : AW'($urandom);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, wa, $urandom,
                 $urandom_range(0, 1) != 0, ia, $urandom_range(0, 19) == 0, r0, r1);
        end
        rd(1, 2);

        repeat (3) @(posedge clk);
        check("queue_drained", DW'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
